// File: rtl/fp_unit_arbiter.sv
// rtl/fp_unit_arbiter.sv - round-robin issue arbiter sharing one fixed-latency pipelined fp32 unit
//
// Shares a stall-free, fully pipelined fp32 unit (result exactly LATENCY cycles after the
// operands are presented) between NREQ requesters. One issue per cycle, round-robin,
// with a per-requester cap on in-flight operations. Requester tags travel down a delay
// line matched to the unit latency so each result is strobed back to its issuer only.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   req_valid/ready    per-requester request / one-hot grant (combinational)
//   req_a, req_b       packed operands, requester i at [32i+31:32i]
//   op_a, op_b         registered operands to the unit
//   op_issue           op_a/op_b carry a real operation this cycle
//   unit_res           unit result input
//   rsp_valid          one-hot result strobe to the issuing requester
//   rsp_data           unit_res passed straight through
//   busy               an op is being issued or any requester has ops in flight
//   perf_grants/stall  (FP_ARB_PERF_EN only) 16-bit saturating per-requester counters
//
// Optional feature macro: FP_ARB_PERF_EN

module fp_unit_arbiter #(
    parameter int NREQ    = 4,
    parameter int LATENCY = 8,
    parameter int MAX_OUT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic [31:0]          op_a,
    output logic [31:0]          op_b,
    output logic                 op_issue,
    input  logic [31:0]          unit_res,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [31:0]          rsp_data,
`ifdef FP_ARB_PERF_EN
    output logic [NREQ*16-1:0]   perf_grants,
    output logic [NREQ*16-1:0]   perf_stall,
`endif
    output logic                 busy
);

    localparam int TAGW = $clog2(NREQ);
    localparam int CNTW = $clog2(MAX_OUT + 1);

    logic [TAGW-1:0] rr_q, rr_d;
    logic [31:0]     op_a_q, op_a_d, op_b_q, op_b_d;
    logic            op_issue_q, op_issue_d;
    logic [CNTW-1:0] cnt_q [NREQ];
    logic [CNTW-1:0] cnt_d [NREQ];

    // Tag delay line: stage 0 is loaded at the handshake edge alongside op_a/op_b,
    // so stage LATENCY lines up with the cycle the unit presents the result.
    logic [LATENCY:0] tv_q;
    logic [TAGW-1:0]  tt_q [LATENCY+1];

    logic [NREQ-1:0] eligible;
    logic            grant_vld;
    logic [TAGW-1:0] grant_idx;
    logic [TAGW-1:0] cand;
    logic            any_out;

    assign op_a     = op_a_q;
    assign op_b     = op_b_q;
    assign op_issue = op_issue_q;
    assign rsp_data = unit_res;

    always_comb begin : rsp_decode
        rsp_valid = '0;
        if (tv_q[LATENCY]) begin
            rsp_valid[tt_q[LATENCY]] = 1'b1;
        end
    end

    // A result returning this cycle frees its slot immediately, so a capped
    // requester can reissue in the same cycle its oldest op completes.
    always_comb begin : elig_grant
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            eligible[i] = req_valid[i] && ((cnt_q[i] < CNTW'(MAX_OUT)) || rsp_valid[i]);
        end
        // Scan from farthest to nearest so the first eligible index after rr_q wins last.
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = TAGW'((int'(rr_q) + k) % NREQ);
            if (eligible[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
        if (grant_vld) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin : next_state
        rr_d       = rr_q;
        op_a_d     = '0;
        op_b_d     = '0;
        op_issue_d = 1'b0;
        if (grant_vld) begin
            op_a_d     = req_a[32*int'(grant_idx) +: 32];
            op_b_d     = req_b[32*int'(grant_idx) +: 32];
            op_issue_d = 1'b1;
            rr_d       = (grant_idx == TAGW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end
        any_out = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (grant_vld && (grant_idx == TAGW'(i)) && !rsp_valid[i]) begin
                cnt_d[i] = cnt_q[i] + CNTW'(1);
            end else if (rsp_valid[i] && !(grant_vld && (grant_idx == TAGW'(i)))) begin
                cnt_d[i] = cnt_q[i] - CNTW'(1);
            end
            if (cnt_q[i] != '0) begin
                any_out = 1'b1;
            end
        end
        busy = op_issue_q || any_out;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q       <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_issue_q <= 1'b0;
            tv_q       <= '0;
            for (int s = 0; s <= LATENCY; s++) begin
                tt_q[s] <= '0;
            end
            for (int i = 0; i < NREQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            rr_q       <= rr_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_issue_q <= op_issue_d;
            tv_q       <= {tv_q[LATENCY-1:0], grant_vld};
            tt_q[0]    <= grant_idx;
            for (int s = 1; s <= LATENCY; s++) begin
                tt_q[s] <= tt_q[s-1];
            end
            for (int i = 0; i < NREQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

`ifdef FP_ARB_PERF_EN
    logic [15:0] pg_q [NREQ];
    logic [15:0] ps_q [NREQ];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (reset) begin
                pg_q[i] <= '0;
                ps_q[i] <= '0;
            end else begin
                if (req_ready[i] && (pg_q[i] != 16'hFFFF)) begin
                    pg_q[i] <= pg_q[i] + 16'd1;
                end
                if (req_valid[i] && !req_ready[i] && (ps_q[i] != 16'hFFFF)) begin
                    ps_q[i] <= ps_q[i] + 16'd1;
                end
            end
        end
    end

    for (genvar gp = 0; gp < NREQ; gp++) begin : g_perf
        assign perf_grants[16*gp +: 16] = pg_q[gp];
        assign perf_stall[16*gp +: 16]  = ps_q[gp];
    end
`endif

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_chk
        a_cnt_max : assert property (@(posedge clk) disable iff (reset)
            cnt_q[gi] <= CNTW'(MAX_OUT));
        a_cnt_under : assert property (@(posedge clk) disable iff (reset)
            !(rsp_valid[gi] && (cnt_q[gi] == '0)));
        a_cnt_over : assert property (@(posedge clk) disable iff (reset)
            !(grant_vld && (grant_idx == TAGW'(gi)) && !rsp_valid[gi] &&
              (cnt_q[gi] == CNTW'(MAX_OUT))));
    end

endmodule
